fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit and its buffer.
package fetch_pkg;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int ENTRY_W = DW + AW;

   localparam logic [AW-1:0] RESET_PC = 32'h0000_0000;
   localparam int            DEPTH    = 2;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small ring of {data, pc} entries with push, pop, flush and occupancy count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int ENTRIES = DEPTH,
   parameter int CW      = $clog2(ENTRIES + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [ENTRY_W-1:0] wdata,
   output logic [ENTRY_W-1:0] rdata,
   output logic [CW-1:0]      count
);

   localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRY_W-1:0] mem_q [ENTRIES];
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]      count_q, count_d;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
   endfunction

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; it is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word addresses, buffers returning words, handles redirect and halt.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
   parameter int          DEPTH    = fetch_pkg::DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        halted
);

   import fetch_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0]      fpc_q, fpc_d;
   logic [AW-1:0]      req_pc_q, req_pc_d;
   logic               inflight_q, inflight_d;
   state_e             state_q, state_d;

   logic [CW-1:0]      count;
   logic [CW:0]        occupancy;
   logic [ENTRY_W-1:0] head;
   logic               pop, push, flush, issue;

   assign inst_valid = (count != '0);
   assign pop        = inst_valid & inst_ready & en;
   assign flush      = en & redirect;
   assign push       = en & ~redirect & inflight_q;

   // Slots that will be committed after this edge: buffered plus in flight, minus what leaves now.
   assign occupancy  = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign issue      = en & ~redirect & (state_q == RUN) & (occupancy < (CW+1)'(DEPTH));

   always_comb begin
      fpc_d      = fpc_q;
      req_pc_d   = req_pc_q;
      inflight_d = inflight_q;
      state_d    = state_q;
      if (flush) begin
         fpc_d      = redirect_pc;
         inflight_d = 1'b0;
         state_d    = RUN;
      end else if (en) begin
         if (issue) begin
            fpc_d      = fpc_q + 1'b1;
            req_pc_d   = fpc_q;
            inflight_d = 1'b1;
         end else begin
            inflight_d = 1'b0;
         end
         if (state_q == RUN && halt) state_d = HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q      <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         state_q    <= RUN;
      end else begin
         fpc_q      <= fpc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         state_q    <= state_d;
      end
   end

   fetch_fifo #(
      .ENTRIES (DEPTH),
      .CW      (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata ({imem_rdata, req_pc_q}),
      .rdata (head),
      .count (count)
   );

   assign imem_addr = fpc_q;
   // Gate the head so an empty buffer presents zeros rather than stale storage.
   assign inst_data = inst_valid ? head[ENTRY_W-1:AW] : '0;
   assign inst_pc   = inst_valid ? head[AW-1:0]       : '0;
   assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: queue-based reference model plus a RESET_PC wrap instance.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, en, redirect, halt, inst_ready;
   logic [31:0] redirect_pc;

   logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc;
   logic        inst_valid, halted;
   logic [31:0] imem_addr2, imem_rdata2, inst_data2, inst_pc2;
   logic        inst_valid2, halted2;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
      .clk(clk), .rst(rst), .en(en),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc), .halted(halted)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .DEPTH(2)) u_dut_wrap (
      .clk(clk), .rst(rst), .en(en),
      .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .inst_valid(inst_valid2), .inst_ready(inst_ready),
      .inst_data(inst_data2), .inst_pc(inst_pc2), .halted(halted2)
   );

   // Synchronous ROMs, word[i] = i + 100, gated by the same enable as the fetch unit.
   always @(posedge clk) if (en) imem_rdata  <= imem_addr  + 32'd100;
   always @(posedge clk) if (en) imem_rdata2 <= imem_addr2 + 32'd100;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: next fetch address, one optional outstanding request, and the
   // expected output queue (pcs buffered, in order). The monitor pops on acceptance.
   logic [31:0] m_fpc, m_req_pc;
   bit          m_infl, m_halt, m_iss;
   bit          armed = 0, fresh = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk) begin
      if (rst) begin
         m_fpc  = 32'h0;
         m_infl = 0;
         m_halt = 0;
         exp_q.delete();
         armed  = 1;
         fresh  = 1;
      end else if (en) begin
         if (redirect) begin
            m_fpc  = redirect_pc;
            m_infl = 0;
            m_halt = 0;
            exp_q.delete();
         end else begin
            // exp_q already excludes a word popped at this edge
            m_iss = !m_halt && (exp_q.size() + int'(m_infl)) < 2;
            if (m_infl) begin
               exp_q.push_back(m_req_pc);
               fresh = 0;
            end
            if (m_iss) begin
               m_req_pc = m_fpc;
               m_fpc    = m_fpc + 32'd1;
            end
            m_infl = m_iss;
            if (halt) m_halt = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_q.size() != 0});
         check("halted", {31'b0, halted}, {31'b0, m_halt});
         check("imem_addr", imem_addr, m_fpc);
         if (exp_q.size() != 0) begin
            check("inst_pc", inst_pc, exp_q[0]);
            check("inst_data", inst_data, exp_q[0] + 32'd100);
            if (inst_ready && en) void'(exp_q.pop_front());
         end else if (fresh) begin
            check("empty_pc", inst_pc, 32'h0);
            check("empty_data", inst_data, 32'h0);
         end
      end
   end

   // Wrap instance: after each reset the accepted pcs must run FFFF_FFFF, 0, 1, ...
   bit          chk2 = 0;
   int          n2 = 0;
   logic [31:0] exp2;

   always @(posedge clk) if (rst) exp2 = 32'hFFFF_FFFF;

   always @(negedge clk) begin
      if (chk2 && inst_valid2 && inst_ready && en) begin
         check("wrap_pc", inst_pc2, exp2);
         check("wrap_data", inst_data2, exp2 + 32'd100);
         exp2 = exp2 + 32'd1;
         n2++;
      end
   end

   task automatic step(input logic r, input logic e, input logic rr, input logic h,
                       input logic rdy, input logic [31:0] rpc, input int n);
      for (int i = 0; i < n; i++) begin
         rst = r; en = e; redirect = rr; halt = h; inst_ready = rdy; redirect_pc = rpc;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // reset release, streaming with ready held high
      step(1, 1, 0, 0, 1, 0, 2);
      step(0, 1, 0, 0, 1, 0, 8);
      // back-pressure: buffer fills, fetch address stalls
      step(0, 1, 0, 0, 0, 0, 5);
      step(0, 1, 0, 0, 1, 0, 4);
      // redirect during steady streaming (one buffered, one in flight)
      step(0, 1, 1, 0, 1, 32'h40, 1);
      step(0, 1, 0, 0, 1, 0, 5);
      // redirect with the buffer full
      step(0, 1, 0, 0, 0, 0, 4);
      step(0, 1, 1, 0, 0, 32'h40, 1);
      step(0, 1, 0, 0, 1, 0, 6);
      // halt pulse, drain, resume from 0
      step(0, 1, 1, 0, 1, 32'h0, 1);
      step(0, 1, 0, 0, 1, 0, 5);
      step(0, 1, 0, 1, 1, 0, 1);
      step(0, 1, 0, 0, 1, 0, 6);
      step(0, 1, 1, 0, 1, 32'h0, 1);
      step(0, 1, 0, 0, 1, 0, 6);
      // enable low mid-stream
      step(0, 0, 0, 0, 1, 0, 3);
      step(0, 1, 0, 0, 1, 0, 5);
      step(0, 0, 0, 1, 0, 32'h99, 2);
      step(0, 1, 0, 0, 1, 0, 4);
      // reset mid-stream with the buffer full
      step(0, 1, 0, 0, 0, 0, 4);
      step(1, 1, 1, 1, 0, 32'h77, 1);
      step(0, 1, 0, 0, 1, 0, 6);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 3) != 0, rpc, 1);
      end

      // RESET_PC wrap, then reset mid-stream
      step(1, 1, 0, 0, 1, 0, 2);
      chk2 = 1;
      step(0, 1, 0, 0, 1, 0, 5);
      step(1, 1, 0, 0, 1, 0, 1);
      check("wrap_valid_after_rst", {31'b0, inst_valid2}, 32'h0);
      step(0, 1, 0, 0, 1, 0, 5);
      check("wrap_halted", {31'b0, halted2}, 32'h0);
      check("wrap_accept_count", (n2 >= 6) ? 32'h1 : 32'h0, 32'h1);
      chk2 = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
